reorder_buffer: RTL

- In-order retirement buffer for the out-of-order core.
- Dispatch allocates an entry per instruction and receives its tag. Functional units complete entries out of order over the common data bus (CDB).
- The block retires the head entry in program order and is the sole writer of register_file: wa_out/we_out/wd_out connect directly to its wa_in/we_in/wd_in.

---
 rtl/riscalar_pkg.sv | 17 +
 rtl/reorder_buffer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/riscalar_pkg.sv
// Shared core definitions: machine word width, register index width and the
// reorder-buffer entry layout.
package riscalar_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // One in-flight instruction tracked by the reorder buffer.
    typedef struct packed {
        logic                  valid;   // entry allocated and not yet retired
        logic                  done;    // result received from the CDB
        logic                  has_rd;  // instruction writes a destination register
        logic [REG_ADDR_W-1:0] rd;      // destination register index
        logic [XLEN-1:0]       data;    // result value
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer. Dispatch allocates entries at the tail, the CDB
// completes them in any order, and the head retires in program order into the
// register file. This block is the only writer of the register file.
//
// Allocation handshake: an entry is granted on a clock edge where
// alloc_valid_in && alloc_ready_out. alloc_ready_out depends only on registered
// state (it is !full), never on alloc_valid_in. alloc_tag_out names the entry
// granted on that edge. A request while not ready is dropped without effect,
// and a retirement in the same cycle does not make room for it.
module reorder_buffer
    import riscalar_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  alloc_valid_in,
    input  logic                  alloc_has_rd_in,
    input  logic [REG_ADDR_W-1:0] alloc_rd_in,
    output logic                  alloc_ready_out,
    output logic [TAG_W-1:0]      alloc_tag_out,
    input  logic                  cdb_valid_in,
    input  logic [TAG_W-1:0]      cdb_tag_in,
    input  logic [XLEN-1:0]       cdb_data_in,
    input  logic                  flush_in,
    output logic [REG_ADDR_W-1:0] wa_out,
    output logic                  we_out,
    output logic [XLEN-1:0]       wd_out,
    output logic [TAG_W:0]        count_out,
    output logic                  empty_out
);

    // Entry storage and pointers. Pointers carry one extra wrap bit so that
    // full and empty can be told apart when the index bits match.
    rob_entry_t            rob_q [DEPTH];
    rob_entry_t            rob_d [DEPTH];
    logic [TAG_W:0]        head_q, head_d;
    logic [TAG_W:0]        tail_q, tail_d;

    // Registered register-file write port.
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] wa_q, wa_d;
    logic [XLEN-1:0]       wd_q, wd_d;

    logic [TAG_W-1:0]      head_idx;
    logic [TAG_W-1:0]      tail_idx;
    logic                  full;
    logic                  empty;
    logic                  alloc_fire;
    logic                  retire;
    logic                  cdb_hit;
    rob_entry_t            head_entry;

    assign head_idx   = head_q[TAG_W-1:0];
    assign tail_idx   = tail_q[TAG_W-1:0];
    assign full       = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign empty      = (head_q == tail_q);
    assign head_entry = rob_q[head_idx];

    // Pending events for this edge; flush suppresses all of them.
    assign alloc_fire = alloc_valid_in && !full && !flush_in;
    assign retire     = head_entry.valid && head_entry.done && !flush_in;
    assign cdb_hit    = cdb_valid_in && rob_q[cdb_tag_in].valid && !flush_in;

    assign alloc_ready_out = !full;
    assign alloc_tag_out   = tail_idx;
    assign count_out       = tail_q - head_q;
    assign empty_out       = empty;
    assign we_out          = we_q;
    assign wa_out          = wa_q;
    assign wd_out          = wd_q;

    // Next entry array and pointers: completion, then retirement, then allocation.
    // The three never collide on one entry except a CDB hitting a retiring head,
    // where retirement still uses the previously registered data.
    always_comb begin
        rob_d  = rob_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_d[i].valid = 1'b0;
                rob_d[i].done  = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end else begin
            if (cdb_hit) begin
                rob_d[cdb_tag_in].done = 1'b1;
                rob_d[cdb_tag_in].data = cdb_data_in;
            end
            if (retire) begin
                rob_d[head_idx].valid = 1'b0;
                rob_d[head_idx].done  = 1'b0;
                head_d                = head_q + 1'b1;
            end
            if (alloc_fire) begin
                rob_d[tail_idx].valid  = 1'b1;
                rob_d[tail_idx].done   = 1'b0;
                rob_d[tail_idx].has_rd = alloc_has_rd_in;
                rob_d[tail_idx].rd     = alloc_rd_in;
                tail_d                 = tail_q + 1'b1;
            end
        end
    end

    // Next register-file write: pulse on retirement, suppressed for x0;
    // address and data hold between retirements.
    always_comb begin
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (retire) begin
            we_d = head_entry.has_rd && (head_entry.rd != '0);
            wa_d = head_entry.rd;
            wd_d = head_entry.data;
        end
    end

    // State registers with asynchronous clear; reset drops any pending write.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= rob_d[i];
            end
            head_q <= head_d;
            tail_q <= tail_d;
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
        end
    end

endmodule
